uart_temp_rx: RTL and testbench

- Receive side of the temperature-count UART link. Sits directly downstream of the temperature-count transmitter.
- Deserialises the 8N1 byte stream and parses each message: 8 uppercase hex ASCII digits, most-significant nibble first, then CR (0x0D) and LF (0x0A).
- Rebuilds the 32-bit low-period clock count and presents it with a one-cycle valid strobe.
- Used for on-chip loopback self-test and for board-level relay of the measurement.

---
 rtl/uart_temp_pkg.sv | 49 ++++
 rtl/uart_rx_byte.sv | 128 ++++++++++++
 rtl/uart_temp_rx.sv | 127 ++++++++++++
 tb/tb_uart_temp_rx.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/uart_temp_pkg.sv
// Shared definitions for the temperature-count UART link (transmit and receive).
//   - ASCII framing constants (CR, LF, '0', 'A')
//   - default clock / baud settings
//   - receiver and parser state encodings
//   - hex_to_nibble(): uppercase hex ASCII -> nibble plus valid flag
package uart_temp_pkg;

  localparam int unsigned DEF_CLK_FREQ  = 50_000_000;
  localparam int unsigned DEF_BAUD_RATE = 115_200;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

  typedef enum logic [1:0] {
    P_DIGITS,
    P_EXP_LF,
    P_RESYNC
  } parse_state_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] nibble;
  } hex_nib_t;

  // Only '0'-'9' and 'A'-'F' are accepted; lowercase is a format error.
  function automatic hex_nib_t hex_to_nibble(input logic [7:0] c);
    hex_nib_t r;
    r = '0;
    if (c >= ASCII_0 && c <= ASCII_0 + 8'd9) begin
      r.valid  = 1'b1;
      r.nibble = 4'(c - ASCII_0);
    end else if (c >= ASCII_A && c <= ASCII_A + 8'd5) begin
      r.valid  = 1'b1;
      r.nibble = 4'(c - ASCII_A + 8'd10);
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver with a two-flop input synchroniser.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   rx_i          : serial line, idle high, asynchronous to clk
//   byte_o        : last deserialised byte (valid while byte_valid_o is high)
//   byte_valid_o  : one-cycle pulse, cycle after a good stop-bit sample
//   frame_err_o   : one-cycle pulse, stop bit sampled low
//   busy_o        : receiver FSM outside IDLE
module uart_rx_byte
  import uart_temp_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = DEF_CLK_FREQ,
  parameter int unsigned BAUD_RATE = DEF_BAUD_RATE
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

  rx_state_e        r_state, w_state_next;
  logic             r_rx_meta, r_rx_s, r_rx_prev;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_byte_valid, r_frame_err;
  logic             w_cnt_clr, w_shift, w_byte_done, w_frame_err;
  logic             w_half, w_bit_end;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx_i;
      r_rx_s    <= r_rx_meta;
      r_rx_prev <= r_rx_s;
    end
  end

  assign w_half    = (r_cnt == CNT_W'(HALF_BIT - 1));
  assign w_bit_end = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= RX_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_clr    = 1'b0;
    w_shift      = 1'b0;
    w_byte_done  = 1'b0;
    w_frame_err  = 1'b0;
    case (r_state)
      RX_IDLE: begin
        if (r_rx_prev && !r_rx_s) begin
          w_cnt_clr    = 1'b1;
          w_state_next = RX_START;
        end
      end
      RX_START: begin
        // A start bit that is high again at mid-bit was a glitch.
        if (w_half) begin
          w_cnt_clr    = 1'b1;
          w_state_next = r_rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (w_bit_end) begin
          w_cnt_clr = 1'b1;
          w_shift   = 1'b1;
          if (r_bit_idx == 3'd7) w_state_next = RX_STOP;
        end
      end
      RX_STOP: begin
        // Leaving at mid stop bit lets the next start edge arrive half a bit early.
        if (w_bit_end) begin
          w_cnt_clr = 1'b1;
          if (r_rx_s) begin
            w_byte_done  = 1'b1;
            w_state_next = RX_IDLE;
          end else begin
            w_frame_err  = 1'b1;
            w_state_next = RX_WAIT_HIGH;
          end
        end
      end
      RX_WAIT_HIGH: begin
        if (r_rx_s) w_state_next = RX_IDLE;
      end
      default: w_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt        <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      if (w_cnt_clr)                   r_cnt <= '0;
      else if (r_state != RX_IDLE &&
               r_state != RX_WAIT_HIGH) r_cnt <= r_cnt + CNT_W'(1);
      if (r_state == RX_START)         r_bit_idx <= '0;
      else if (w_shift)                r_bit_idx <= r_bit_idx + 3'd1;
      if (w_shift)                     r_shift <= {r_rx_s, r_shift[7:1]};
      r_byte_valid <= w_byte_done;
      r_frame_err  <= w_frame_err;
    end
  end

  assign byte_o       = r_shift;
  assign byte_valid_o = r_byte_valid;
  assign frame_err_o  = r_frame_err;
  assign busy_o       = (r_state != RX_IDLE);

endmodule

// File: rtl/uart_temp_rx.sv
// Receive side of the temperature-count link: deserialises 8N1 bytes and parses
// "HHHHHHHH\r\n" messages (uppercase hex, MS nibble first) into a count.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   uart_rx_i      : serial line, idle high
//   count_o        : last correctly received count, held until next good message
//   count_valid_o  : one-cycle pulse, count_o updated this cycle
//   frame_err_o    : one-cycle pulse, stop bit sampled low
//   format_err_o   : one-cycle pulse, malformed message (at most one per message)
//   busy_o         : bit receiver outside IDLE
module uart_temp_rx
  import uart_temp_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
  parameter int unsigned BAUD_RATE  = DEF_BAUD_RATE,
  parameter int unsigned HEX_DIGITS = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    uart_rx_i,
  output logic [4*HEX_DIGITS-1:0] count_o,
  output logic                    count_valid_o,
  output logic                    frame_err_o,
  output logic                    format_err_o,
  output logic                    busy_o
);

  localparam int unsigned CW = 4 * HEX_DIGITS;
  localparam int unsigned DW = $clog2(HEX_DIGITS + 1);

  logic [7:0]   w_byte;
  logic         w_byte_valid, w_frame_err;
  hex_nib_t     w_nib;

  parse_state_e r_pstate, w_pstate_next;
  logic [CW-1:0] r_acc, r_count;
  logic [DW-1:0] r_digits;
  logic          r_count_valid, r_format_err;
  logic          w_push_digit, w_load, w_fmt_err, w_clr_digits;

  uart_rx_byte #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) u_rx (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx_i        (uart_rx_i),
    .byte_o      (w_byte),
    .byte_valid_o(w_byte_valid),
    .frame_err_o (w_frame_err),
    .busy_o      (busy_o)
  );

  assign w_nib = hex_to_nibble(w_byte);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_pstate <= P_DIGITS;
    else          r_pstate <= w_pstate_next;
  end

  always_comb begin
    w_pstate_next = r_pstate;
    w_push_digit  = 1'b0;
    w_load        = 1'b0;
    w_fmt_err     = 1'b0;
    w_clr_digits  = 1'b0;
    if (w_frame_err) begin
      w_pstate_next = P_RESYNC;
    end else if (w_byte_valid) begin
      case (r_pstate)
        P_DIGITS: begin
          if (w_nib.valid && r_digits < DW'(HEX_DIGITS)) begin
            w_push_digit = 1'b1;
          end else if (w_byte == ASCII_CR && r_digits == DW'(HEX_DIGITS)) begin
            w_pstate_next = P_EXP_LF;
          end else begin
            w_fmt_err     = 1'b1;
            w_pstate_next = P_RESYNC;
          end
        end
        P_EXP_LF: begin
          if (w_byte == ASCII_LF) begin
            w_load        = 1'b1;
            w_clr_digits  = 1'b1;
            w_pstate_next = P_DIGITS;
          end else begin
            w_fmt_err     = 1'b1;
            w_pstate_next = P_RESYNC;
          end
        end
        P_RESYNC: begin
          if (w_byte == ASCII_LF) begin
            w_clr_digits  = 1'b1;
            w_pstate_next = P_DIGITS;
          end
        end
        default: w_pstate_next = P_RESYNC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc         <= '0;
      r_count       <= '0;
      r_digits      <= '0;
      r_count_valid <= 1'b0;
      r_format_err  <= 1'b0;
    end else begin
      if (w_push_digit) begin
        r_acc    <= {r_acc[CW-5:0], w_nib.nibble};
        r_digits <= r_digits + DW'(1);
      end else if (w_clr_digits) begin
        r_digits <= '0;
      end
      if (w_load) r_count <= r_acc;
      r_count_valid <= w_load;
      r_format_err  <= w_fmt_err;
    end
  end

  assign count_o       = r_count;
  assign count_valid_o = r_count_valid;
  assign frame_err_o   = w_frame_err;
  assign format_err_o  = r_format_err;

endmodule

// File: tb/tb_uart_temp_rx.sv
// Scoreboard bench for uart_temp_rx: expected counts are queued as messages are
// driven and compared whenever count_valid_o pulses.
module tb_uart_temp_rx;
  import uart_temp_pkg::*;

  localparam int unsigned CLK_FREQ  = 50_000_000;
  localparam int unsigned BAUD_RATE = 2_500_000;
  localparam int unsigned CPB       = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF      = CPB / 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx = 1'b1;
  logic [31:0] count_o;
  logic        count_valid_o, frame_err_o, format_err_o, busy_o;

  int          errors = 0;
  int          checks = 0;
  int          n_frame = 0;
  int          n_fmt = 0;
  logic [31:0] q_exp[$];

  always #10 clk = ~clk;

  uart_temp_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .HEX_DIGITS(8)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .uart_rx_i    (rx),
    .count_o      (count_o),
    .count_valid_o(count_valid_o),
    .frame_err_o  (frame_err_o),
    .format_err_o (format_err_o),
    .busy_o       (busy_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (frame_err_o)  n_frame++;
      if (format_err_o) n_fmt++;
      if (32'(count_valid_o) + 32'(frame_err_o) + 32'(format_err_o) > 32'd1)
        check_eq("pulse_exclusive", 32'(count_valid_o) + 32'(frame_err_o) + 32'(format_err_o), 32'd1);
      if (count_valid_o) begin
        if (q_exp.size() == 0) check_eq("unexpected_valid", 32'(count_valid_o), 32'd0);
        else                   check_eq("count", count_o, q_exp.pop_front());
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_msg(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    send_byte(ASCII_CR, 1'b1);
    send_byte(ASCII_LF, 1'b1);
  endtask

  task automatic wait_sb();
    for (int i = 0; i < 40 * CPB && q_exp.size() != 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    check_eq("sb_drain", 32'(q_exp.size()), 32'd0);
  endtask

  initial begin
    int fr0, fm0, len;

    reset_n = 1'b0;
    rx      = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("rst_count", count_o, 32'd0);
    check_eq("rst_valid", 32'(count_valid_o), 32'd0);
    check_eq("rst_frame", 32'(frame_err_o), 32'd0);
    check_eq("rst_format", 32'(format_err_o), 32'd0);
    check_eq("rst_busy", 32'(busy_o), 32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // single message
    q_exp.push_back(32'h00001A2F);
    send_msg("00001A2F");
    wait_sb();
    check_eq("t1_count_hold", count_o, 32'h00001A2F);
    check_eq("t1_frame_errs", 32'(n_frame), 32'd0);
    check_eq("t1_format_errs", 32'(n_fmt), 32'd0);

    // back-to-back, no idle between stop and next start
    q_exp.push_back(32'hFFFFFFFF);
    q_exp.push_back(32'h00000000);
    send_msg("FFFFFFFF");
    send_msg("00000000");
    wait_sb();
    check_eq("t2_format_errs", 32'(n_fmt), 32'd0);

    // lowercase digit -> one format error, count held
    fm0 = n_fmt;
    send_msg("0000a2F0");
    repeat (4) @(negedge clk);
    check_eq("t3_format_pulse", 32'(n_fmt - fm0), 32'd1);
    check_eq("t3_count_held", count_o, 32'h00000000);
    q_exp.push_back(32'h12345678);
    send_msg("12345678");
    wait_sb();
    check_eq("t3_format_total", 32'(n_fmt - fm0), 32'd1);

    // stop bit low followed by a held-low break
    fr0 = n_frame;
    fm0 = n_fmt;
    send_byte(8'h41, 1'b0);
    rx = 1'b0;
    repeat (500) @(negedge clk);
    check_eq("t4_busy_in_break", 32'(busy_o), 32'd1);
    check_eq("t4_frame_pulse", 32'(n_frame - fr0), 32'd1);
    rx = 1'b1;
    repeat (6) @(negedge clk);
    check_eq("t4_busy_released", 32'(busy_o), 32'd0);
    // parser is resyncing: the first message is consumed up to its LF
    send_msg("DEADBEEF");
    q_exp.push_back(32'h0BADF00D);
    send_msg("0BADF00D");
    wait_sb();
    check_eq("t4_frame_total", 32'(n_frame - fr0), 32'd1);
    check_eq("t4_no_format", 32'(n_fmt - fm0), 32'd0);

    // short low glitch on an idle line
    repeat (3 * CPB) @(negedge clk);
    fr0 = n_frame;
    fm0 = n_fmt;
    len = 0;
    rx  = 1'b0;
    for (int i = 0; i < 4 * CPB; i++) begin
      if (i == 5) rx = 1'b1;
      @(negedge clk);
      if (busy_o) len++;
    end
    check_eq("t5_busy_len", 32'(len), 32'(HALF));
    check_eq("t5_no_frame", 32'(n_frame - fr0), 32'd0);
    check_eq("t5_no_format", 32'(n_fmt - fm0), 32'd0);
    check_eq("t5_count_held", count_o, 32'h0BADF00D);

    // reset in the middle of a message
    send_byte("1", 1'b1);
    send_byte("2", 1'b1);
    send_byte("3", 1'b1);
    send_byte("4", 1'b1);
    rx = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    reset_n = 1'b0;
    rx      = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("t6_rst_count", count_o, 32'd0);
    check_eq("t6_rst_valid", 32'(count_valid_o), 32'd0);
    check_eq("t6_rst_frame", 32'(frame_err_o), 32'd0);
    check_eq("t6_rst_format", 32'(format_err_o), 32'd0);
    check_eq("t6_rst_busy", 32'(busy_o), 32'd0);
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    fm0 = n_fmt;
    q_exp.push_back(32'hCAFE0001);
    send_msg("CAFE0001");
    wait_sb();
    check_eq("t6_count_hold", count_o, 32'hCAFE0001);
    check_eq("t6_no_format", 32'(n_fmt - fm0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
